// File: rtl/rvj1_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rvj1_pkg
// Description : Shared core widths, reset vector, NOP encoding and fetch FSM
//               state type.
// Revision    : 1.0 - initial release
// ============================================================================
package rvj1_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned INSTR_W = 32;

    localparam logic [XLEN-1:0]    RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [INSTR_W-1:0] NOP_INSTR        = 32'h0000_0013;

    // BUSY means exactly one memory read is outstanding.
    typedef enum logic [0:0] {
        FETCH_IDLE = 1'b0,
        FETCH_BUSY = 1'b1
    } fetch_state_t;

endpackage : rvj1_pkg
`default_nettype wire

// File: rtl/instr_fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_unit_if
// Description : Fetch-to-decode valid/ready handshake carrying an instruction
//               word and its byte-address PC.
// Revision    : 1.0 - initial release
// ============================================================================
interface instr_fetch_unit_if
    import rvj1_pkg::*;
#(
    parameter int unsigned DATA_W = INSTR_W,
    parameter int unsigned ADDR_W = XLEN
);

    logic              instr_valid;
    logic              instr_ready;
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] instr_pc;

    modport master (
        output instr_valid,
        output instr,
        output instr_pc,
        input  instr_ready
    );

    modport slave (
        input  instr_valid,
        input  instr,
        input  instr_pc,
        output instr_ready
    );

endinterface : instr_fetch_unit_if
`default_nettype wire

// File: rtl/instr_fetch_unit_fifo2.sv
`default_nettype none
// ============================================================================
// Module      : fetch_fifo2
// Description : Two-entry FIFO with flush; head entry drives dout directly.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo2 #(
    parameter int unsigned WIDTH = 64
) (
    input  wire logic             clk,
    input  wire logic             rstn,
    input  wire logic             flush,
    input  wire logic             push,
    input  wire logic             pop,
    input  wire logic [WIDTH-1:0] din,
    output logic      [WIDTH-1:0] dout,
    output logic      [1:0]       count
);

    logic [WIDTH-1:0] r_mem [2];
    logic             r_rd_ptr;
    logic             r_wr_ptr;
    logic [1:0]       r_count;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < 2; i++) begin
                r_mem[i] <= '0;
            end
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else if (flush) begin
            // Storage is left as-is: with count cleared nothing stale is visible.
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (push) begin
                r_mem[r_wr_ptr] <= din;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + {1'b0, push} - {1'b0, pop};
        end
    end

    assign dout  = r_mem[r_rd_ptr];
    assign count = r_count;

    a_no_overflow : assert property (
        @(posedge clk) disable iff (!rstn)
        !(push && !pop && !flush && (r_count == 2'd2))
    );

    a_no_underflow : assert property (
        @(posedge clk) disable iff (!rstn)
        !(pop && !flush && (r_count == 2'd0))
    );

endmodule : fetch_fifo2
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_unit
// Description : Fetch stage: drives a 1-cycle-latency instruction memory,
//               keeps one read in flight, buffers returns for decode and
//               flushes on redirect from execute.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_unit
    import rvj1_pkg::*;
#(
    parameter int unsigned        ADDR_W   = XLEN,
    parameter int unsigned        DATA_W   = INSTR_W,
    parameter int unsigned        MEM_AW   = 4,
    parameter logic [ADDR_W-1:0]  RESET_PC = RESET_PC_DEFAULT
) (
    input  wire logic              clk,
    input  wire logic              rstn,

    output logic                   mem_en,
    output logic      [MEM_AW-1:0] mem_addr,
    input  wire logic [DATA_W-1:0] mem_rdata,

    input  wire logic              redir_valid,
    input  wire logic [ADDR_W-1:0] redir_pc,

    instr_fetch_unit_if.master     dec
);

    localparam int unsigned C_ENTRY_W = DATA_W + ADDR_W;

    fetch_state_t      r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_req_pc;

    logic                 w_inflight;
    logic                 w_pop;
    logic                 w_push;
    logic                 w_issue;
    logic [1:0]           w_count;
    logic [2:0]           w_occupancy;
    logic [ADDR_W-1:0]    w_redir_pc;
    logic [C_ENTRY_W-1:0] w_head;

    assign w_inflight = (r_state == FETCH_BUSY);
    assign w_pop      = dec.instr_valid & dec.instr_ready;
    assign w_redir_pc = redir_pc & ~ADDR_W'(3);

    // Occupancy counts the outstanding read as a reserved slot, so the FIFO
    // can never be asked to take a third word.
    assign w_occupancy = {1'b0, w_count} + {2'b00, w_inflight} - {2'b00, w_pop};
    assign w_issue     = rstn & ~redir_valid & (w_occupancy < 3'd2);

    // A redirect in the return cycle kills the word coming back from memory.
    assign w_push = w_inflight & ~redir_valid;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state  <= FETCH_IDLE;
            r_pc     <= RESET_PC;
            r_req_pc <= '0;
        end else if (redir_valid) begin
            r_state <= FETCH_IDLE;
            r_pc    <= w_redir_pc;
        end else if (w_issue) begin
            r_state  <= FETCH_BUSY;
            r_req_pc <= r_pc;
            r_pc     <= r_pc + ADDR_W'(4);
        end else begin
            r_state <= FETCH_IDLE;
        end
    end

    fetch_fifo2 #(
        .WIDTH (C_ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .flush (redir_valid),
        .push  (w_push),
        .pop   (w_pop),
        .din   ({mem_rdata, r_req_pc}),
        .dout  (w_head),
        .count (w_count)
    );

    assign mem_en   = w_issue;
    assign mem_addr = r_pc[MEM_AW+1:2];

    assign dec.instr_valid = (w_count != 2'd0);
    assign dec.instr       = w_head[C_ENTRY_W-1:ADDR_W];
    assign dec.instr_pc    = w_head[ADDR_W-1:0];

endmodule : instr_fetch_unit
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch_unit
// Description : Directed bench for instr_fetch_unit against a 16-word ROM
//               (word k = k, word 15 = FFFF_FFFF).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_unit;

    typedef struct packed {
        logic        ready;
        logic        redir;
        logic [31:0] rpc;
        logic        v;
        logic [31:0] ins;
        logic [31:0] pc;
        logic        men;
    } vec_t;

    localparam int NVEC = 28;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        mem_en;
    logic [3:0]  mem_addr;
    logic [31:0] mem_rdata = 32'h0;
    logic        redir_valid = 1'b0;
    logic [31:0] redir_pc = 32'h0;
    logic [31:0] rom [16];

    int checks = 0;
    int errors = 0;
    vec_t tbl [NVEC];

    instr_fetch_unit_if #(.DATA_W(32), .ADDR_W(32)) dec_if ();

    instr_fetch_unit #(
        .ADDR_W   (32),
        .DATA_W   (32),
        .MEM_AW   (4),
        .RESET_PC (32'h0)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .mem_en      (mem_en),
        .mem_addr    (mem_addr),
        .mem_rdata   (mem_rdata),
        .redir_valid (redir_valid),
        .redir_pc    (redir_pc),
        .dec         (dec_if)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_en) mem_rdata <= rom[mem_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic rdy, input logic rv, input logic [31:0] rp,
                                input logic v, input logic [31:0] ins,
                                input logic [31:0] pc, input logic men);
        vec_t r;
        r.ready = rdy; r.redir = rv; r.rpc = rp;
        r.v = v; r.ins = ins; r.pc = pc; r.men = men;
        return r;
    endfunction

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " mem_en"},      {31'b0, mem_en},             32'h0);
        chk({tag, " instr_valid"}, {31'b0, dec_if.instr_valid}, 32'h0);
        chk({tag, " instr"},       dec_if.instr,                32'h0);
        chk({tag, " instr_pc"},    dec_if.instr_pc,             32'h0);
    endtask

    initial begin
        for (int k = 0; k < 16; k++) rom[k] = k;
        rom[15] = 32'hFFFF_FFFF;

        // Reset release, backpressure, redirect-while-full, redirect with read
        // in flight, three back-to-back redirects.
        tbl[0]  = mk(1, 0, 32'h00, 0, 32'h0, 32'h00, 1);
        tbl[1]  = mk(1, 0, 32'h00, 0, 32'h0, 32'h00, 1);
        tbl[2]  = mk(1, 0, 32'h00, 1, 32'h0, 32'h00, 1);
        tbl[3]  = mk(0, 0, 32'h00, 1, 32'h1, 32'h04, 0);
        tbl[4]  = mk(0, 0, 32'h00, 1, 32'h1, 32'h04, 0);
        tbl[5]  = mk(0, 0, 32'h00, 1, 32'h1, 32'h04, 0);
        tbl[6]  = mk(0, 0, 32'h00, 1, 32'h1, 32'h04, 0);
        tbl[7]  = mk(0, 0, 32'h00, 1, 32'h1, 32'h04, 0);
        tbl[8]  = mk(1, 0, 32'h00, 1, 32'h1, 32'h04, 1);
        tbl[9]  = mk(1, 0, 32'h00, 1, 32'h2, 32'h08, 1);
        tbl[10] = mk(1, 0, 32'h00, 1, 32'h3, 32'h0C, 1);
        tbl[11] = mk(0, 0, 32'h00, 1, 32'h4, 32'h10, 0);
        tbl[12] = mk(0, 1, 32'h20, 1, 32'h4, 32'h10, 0);
        tbl[13] = mk(1, 0, 32'h00, 0, 32'h0, 32'h00, 1);
        tbl[14] = mk(1, 0, 32'h00, 0, 32'h0, 32'h00, 1);
        tbl[15] = mk(1, 0, 32'h00, 1, 32'h8, 32'h20, 1);
        tbl[16] = mk(1, 0, 32'h00, 1, 32'h9, 32'h24, 1);
        tbl[17] = mk(1, 1, 32'h2B, 1, 32'hA, 32'h28, 0);
        tbl[18] = mk(1, 0, 32'h00, 0, 32'h0, 32'h00, 1);
        tbl[19] = mk(1, 0, 32'h00, 0, 32'h0, 32'h00, 1);
        tbl[20] = mk(1, 0, 32'h00, 1, 32'hA, 32'h28, 1);
        tbl[21] = mk(1, 1, 32'h04, 1, 32'hB, 32'h2C, 0);
        tbl[22] = mk(1, 1, 32'h10, 0, 32'h0, 32'h00, 0);
        tbl[23] = mk(1, 1, 32'h30, 0, 32'h0, 32'h00, 0);
        tbl[24] = mk(1, 0, 32'h00, 0, 32'h0, 32'h00, 1);
        tbl[25] = mk(1, 0, 32'h00, 0, 32'h0, 32'h00, 1);
        tbl[26] = mk(1, 0, 32'h00, 1, 32'hC, 32'h30, 1);
        tbl[27] = mk(1, 0, 32'h00, 1, 32'hD, 32'h34, 1);

        dec_if.instr_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk_reset_outputs("reset");

        // Sustained stream through address wrap.
        @(negedge clk);
        rstn = 1'b1;
        for (int k = 0; k < 19; k++) begin
            logic [31:0] idx;
            logic [31:0] exp_w;
            #1;
            idx   = (k - 2) & 32'hF;
            exp_w = (idx == 32'hF) ? 32'hFFFF_FFFF : idx;
            chk($sformatf("stream%0d mem_en", k), {31'b0, mem_en}, 32'h1);
            chk($sformatf("stream%0d valid", k), {31'b0, dec_if.instr_valid}, {31'b0, (k >= 2)});
            if (k >= 2) begin
                chk($sformatf("stream%0d instr", k), dec_if.instr, exp_w);
                chk($sformatf("stream%0d pc", k), dec_if.instr_pc, 32'(4 * (k - 2)));
            end
            @(negedge clk);
        end

        // Fresh start for the table-driven sequence.
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < NVEC; i++) begin
            dec_if.instr_ready = tbl[i].ready;
            redir_valid        = tbl[i].redir;
            redir_pc           = tbl[i].rpc;
            #1;
            chk($sformatf("vec%0d mem_en", i), {31'b0, mem_en}, {31'b0, tbl[i].men});
            chk($sformatf("vec%0d valid", i), {31'b0, dec_if.instr_valid}, {31'b0, tbl[i].v});
            if (tbl[i].v) begin
                chk($sformatf("vec%0d instr", i), dec_if.instr, tbl[i].ins);
                chk($sformatf("vec%0d pc", i), dec_if.instr_pc, tbl[i].pc);
            end
            @(negedge clk);
        end

        // Reset asserted mid-stream with the FIFO holding words.
        redir_valid        = 1'b0;
        dec_if.instr_ready = 1'b1;
        rstn = 1'b0;
        #1;
        chk_reset_outputs("midreset");
        @(negedge clk);
        rstn = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("restart%0d valid", k), {31'b0, dec_if.instr_valid}, {31'b0, (k >= 2)});
            if (k >= 2) begin
                chk($sformatf("restart%0d instr", k), dec_if.instr, 32'(k - 2));
                chk($sformatf("restart%0d pc", k), dec_if.instr_pc, 32'(4 * (k - 2)));
            end
            @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_instr_fetch_unit
`default_nettype wire
